fast_keypoint_collector: RTL and testbench

//  Consumes the marked-pixel stream from the 7x7 FAST non-maximum-suppression stage and turns each surviving

---
 rtl/fast_keypoint_collector_if.sv | 28 ++
 rtl/fast_keypoint_collector.sv | 161 ++++++++++++++++
 tb/tb_fast_keypoint_collector.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fast_keypoint_collector_if.sv
// Bundles the pixel stream, the keypoint record port and the status outputs
// of the FAST keypoint collector. master = upstream/consumer side, slave = collector.
interface fast_keypoint_collector_if #(
  parameter int COORD_W = 11
);
  logic               image_vs;
  logic               image_hs;
  logic               image_en;
  logic [7:0]         image_data;
  logic               kp_valid;
  logic               kp_ready;
  logic [COORD_W-1:0] kp_x;
  logic [COORD_W-1:0] kp_y;
  logic [1:0]         kp_type;
  logic [15:0]        kp_count;
  logic               frame_done;
  logic               overflow;

  modport master (
    output image_vs, image_hs, image_en, image_data, kp_ready,
    input  kp_valid, kp_x, kp_y, kp_type, kp_count, frame_done, overflow
  );

  modport slave (
    input  image_vs, image_hs, image_en, image_data, kp_ready,
    output kp_valid, kp_x, kp_y, kp_type, kp_count, frame_done, overflow
  );
endinterface

// File: rtl/fast_keypoint_collector.sv
// FAST keypoint collector: tracks pixel coordinates of the NMS marker stream,
// keeps keypoints outside the descriptor border, and queues {x,y,type} records
// in a first-word-fall-through FIFO with a registered output slot.
module fast_keypoint_collector #(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int COORD_W    = 11,
  parameter int BORDER     = 16,
  parameter int MAX_KP     = 500,
  parameter int FIFO_DEPTH = 64
) (
  input logic clk,
  input logic rst,
  fast_keypoint_collector_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = 2 * COORD_W + 2;
  localparam logic [COORD_W-1:0] X_LO      = COORD_W'(BORDER);
  localparam logic [COORD_W-1:0] X_HI      = COORD_W'(IMG_W - BORDER);
  localparam logic [COORD_W-1:0] Y_LO      = COORD_W'(BORDER);
  localparam logic [COORD_W-1:0] Y_HI      = COORD_W'(IMG_H - BORDER);
  localparam logic [COORD_W-1:0] COORD_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t             state_reg;
  logic               vs_reg;
  logic               hs_reg;
  logic               line_seen_reg;
  logic [COORD_W-1:0] x_reg;
  logic [COORD_W-1:0] y_reg;
  logic [15:0]        kp_cnt_reg;
  logic [15:0]        kp_count_reg;
  logic               frame_done_reg;
  logic               s1_valid_reg;
  logic [RW-1:0]      s1_rec_reg;

  logic [RW-1:0]      mem [FIFO_DEPTH];
  logic [AW:0]        wr_ptr_reg;
  logic [AW:0]        rd_ptr_reg;
  logic               kp_valid_reg;
  logic [COORD_W-1:0] kp_x_reg;
  logic [COORD_W-1:0] kp_y_reg;
  logic [1:0]         kp_type_reg;
  logic               overflow_reg;

  logic vs_rise, vs_fall, hs_fall, frame_start, pix_ok, in_window, accept;
  logic [AW:0]   fifo_level;
  logic [AW+1:0] occupancy;
  logic fifo_empty, full, wr_en, drop, load_out;
  logic unused_marker_bits;

  assign vs_rise     = bus.image_vs & ~vs_reg;
  assign vs_fall     = ~bus.image_vs & vs_reg;
  assign hs_fall     = ~bus.image_hs & hs_reg;
  assign frame_start = (state_reg == IDLE) & vs_rise;
  assign pix_ok      = (state_reg == ACTIVE) & bus.image_vs & bus.image_en;
  assign in_window   = (x_reg >= X_LO) && (x_reg < X_HI) && (y_reg >= Y_LO) && (y_reg < Y_HI);
  assign accept      = pix_ok & (bus.image_data[1:0] != 2'b00) & in_window
                       & (kp_cnt_reg < 16'(MAX_KP));
  assign unused_marker_bits = ^bus.image_data[7:2];

  // Capacity counts the output slot too, so the collector holds FIFO_DEPTH records in total.
  assign fifo_level = wr_ptr_reg - rd_ptr_reg;
  assign occupancy  = {1'b0, fifo_level} + {{(AW+1){1'b0}}, kp_valid_reg};
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign full       = (occupancy >= (AW+2)'(FIFO_DEPTH));
  assign wr_en      = s1_valid_reg & ~full;
  assign drop       = s1_valid_reg & full;
  assign load_out   = ~fifo_empty & (~kp_valid_reg | bus.kp_ready);

  // Frame FSM, pixel coordinate tracking, keypoint acceptance and stage-1 record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      vs_reg         <= 1'b1;  // VS already high at release must not look like a frame start
      hs_reg         <= 1'b0;
      line_seen_reg  <= 1'b0;
      x_reg          <= '0;
      y_reg          <= '0;
      kp_cnt_reg     <= '0;
      kp_count_reg   <= '0;
      frame_done_reg <= 1'b0;
      s1_valid_reg   <= 1'b0;
      s1_rec_reg     <= '0;
    end else begin
      vs_reg         <= bus.image_vs;
      hs_reg         <= bus.image_hs;
      frame_done_reg <= 1'b0;
      s1_valid_reg   <= accept;
      if (accept) s1_rec_reg <= {x_reg, y_reg, bus.image_data[1:0]};
      case (state_reg)
        IDLE: begin
          if (vs_rise) begin
            state_reg     <= ACTIVE;
            x_reg         <= '0;
            y_reg         <= '0;
            kp_cnt_reg    <= '0;
            line_seen_reg <= 1'b0;
          end
        end
        ACTIVE: begin
          if (vs_fall) begin
            state_reg      <= DONE;
            frame_done_reg <= 1'b1;
            kp_count_reg   <= kp_cnt_reg;
          end else begin
            if (hs_fall) begin
              x_reg         <= '0;
              line_seen_reg <= 1'b0;
              if ((line_seen_reg | pix_ok) && (y_reg != COORD_MAX)) y_reg <= y_reg + 1'b1;
            end else if (pix_ok) begin
              line_seen_reg <= 1'b1;
              if (x_reg != COORD_MAX) x_reg <= x_reg + 1'b1;
            end
            if (accept) kp_cnt_reg <= kp_cnt_reg + 16'd1;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Record storage; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg[AW-1:0]] <= s1_rec_reg;
  end

  // FIFO pointers, registered output slot and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      kp_valid_reg <= 1'b0;
      kp_x_reg     <= '0;
      kp_y_reg     <= '0;
      kp_type_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (load_out) begin
        rd_ptr_reg   <= rd_ptr_reg + 1'b1;
        kp_valid_reg <= 1'b1;
        {kp_x_reg, kp_y_reg, kp_type_reg} <= mem[rd_ptr_reg[AW-1:0]];
      end else if (bus.kp_ready) begin
        kp_valid_reg <= 1'b0;
      end
      if (drop) overflow_reg <= 1'b1;
      else if (frame_start) overflow_reg <= 1'b0;
    end
  end

  assign bus.kp_valid   = kp_valid_reg;
  assign bus.kp_x       = kp_x_reg;
  assign bus.kp_y       = kp_y_reg;
  assign bus.kp_type    = kp_type_reg;
  assign bus.kp_count   = kp_count_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.overflow   = overflow_reg;
endmodule

// File: tb/tb_fast_keypoint_collector.sv
// Directed bench for fast_keypoint_collector: three instances (default FIFO/cap,
// FIFO_DEPTH=4, MAX_KP=3) share one 64x48 pixel stream with independent ready.
module tb_fast_keypoint_collector;
  localparam int W = 64;
  localparam int H = 48;

  logic clk, rst;
  logic vs, hs, en;
  logic [7:0] data;
  logic rdy_main, rdy_ovf, rdy_cap;
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  fast_keypoint_collector_if #(.COORD_W(11)) if_main ();
  fast_keypoint_collector_if #(.COORD_W(11)) if_ovf ();
  fast_keypoint_collector_if #(.COORD_W(11)) if_cap ();

  assign if_main.image_vs = vs;  assign if_main.image_hs = hs;
  assign if_main.image_en = en;  assign if_main.image_data = data;
  assign if_main.kp_ready = rdy_main;
  assign if_ovf.image_vs = vs;   assign if_ovf.image_hs = hs;
  assign if_ovf.image_en = en;   assign if_ovf.image_data = data;
  assign if_ovf.kp_ready = rdy_ovf;
  assign if_cap.image_vs = vs;   assign if_cap.image_hs = hs;
  assign if_cap.image_en = en;   assign if_cap.image_data = data;
  assign if_cap.kp_ready = rdy_cap;

  fast_keypoint_collector #(.IMG_W(W), .IMG_H(H), .BORDER(4)) u_main (
    .clk(clk), .rst(rst), .bus(if_main));
  fast_keypoint_collector #(.IMG_W(W), .IMG_H(H), .BORDER(4), .FIFO_DEPTH(4)) u_ovf (
    .clk(clk), .rst(rst), .bus(if_ovf));
  fast_keypoint_collector #(.IMG_W(W), .IMG_H(H), .BORDER(4), .MAX_KP(3)) u_cap (
    .clk(clk), .rst(rst), .bus(if_cap));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: collects popped records, frame_done pulses and hold violations.
  logic [23:0] q_main[$], q_ovf[$], q_cap[$];
  int pop_cyc[$];
  int done_main = 0, done_ovf = 0, done_cap = 0;
  int cnt_main = 0, cnt_ovf = 0, cnt_cap = 0;
  int first_valid_cyc = -1;
  int stab_err = 0;
  logic prev_valid_main = 1'b0;
  logic hold_main = 1'b0;
  logic [24:0] held_main = '0;

  always @(negedge clk) begin
    if (if_main.kp_valid && rdy_main) begin
      q_main.push_back({if_main.kp_x, if_main.kp_y, if_main.kp_type});
      pop_cyc.push_back(cyc);
    end
    if (if_main.kp_valid && !prev_valid_main && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (hold_main && ({if_main.kp_valid, if_main.kp_x, if_main.kp_y, if_main.kp_type} != held_main))
      stab_err++;
    hold_main = if_main.kp_valid && !rdy_main;
    held_main = {if_main.kp_valid, if_main.kp_x, if_main.kp_y, if_main.kp_type};
    prev_valid_main = if_main.kp_valid;
    if (if_main.frame_done) begin done_main++; cnt_main = int'(if_main.kp_count); end
    if (if_ovf.kp_valid && rdy_ovf) q_ovf.push_back({if_ovf.kp_x, if_ovf.kp_y, if_ovf.kp_type});
    if (if_ovf.frame_done) begin done_ovf++; cnt_ovf = int'(if_ovf.kp_count); end
    if (if_cap.kp_valid && rdy_cap) q_cap.push_back({if_cap.kp_x, if_cap.kp_y, if_cap.kp_type});
    if (if_cap.frame_done) begin done_cap++; cnt_cap = int'(if_cap.kp_count); end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_main_zero(input string tag);
    check({tag, "_valid"},    int'(if_main.kp_valid), 0);
    check({tag, "_x"},        int'(if_main.kp_x), 0);
    check({tag, "_y"},        int'(if_main.kp_y), 0);
    check({tag, "_type"},     int'(if_main.kp_type), 0);
    check({tag, "_count"},    int'(if_main.kp_count), 0);
    check({tag, "_done"},     int'(if_main.frame_done), 0);
    check({tag, "_overflow"}, int'(if_main.overflow), 0);
  endtask

  // Frame description used by run_frame.
  int fx[$], fy[$], mk_cyc[$];
  logic [1:0] ft[$];
  int rst_line = -1;

  task automatic set_markers(input int n, input int xs[6], input int ys[6], input int ts[6]);
    fx.delete(); fy.delete(); ft.delete();
    for (int i = 0; i < n; i++) begin
      fx.push_back(xs[i]); fy.push_back(ys[i]); ft.push_back(2'(ts[i]));
    end
  endtask

  task automatic run_frame();
    mk_cyc.delete();
    for (int i = 0; i < fx.size(); i++) mk_cyc.push_back(-1);
    step(); vs = 1'b1;
    step(); step();
    for (int yy = 0; yy < H; yy++) begin
      if (yy == rst_line) begin
        rst = 1'b1;
        step();
        check_main_zero("midframe_reset");
        step(); rst = 1'b0;
        step();
      end
      for (int xx = 0; xx < W; xx++) begin
        step(); hs = 1'b1; en = 1'b1; data = 8'hFC;
        for (int i = 0; i < fx.size(); i++)
          if (fx[i] == xx && fy[i] == yy) begin
            data = {6'b101101, ft[i]};
            mk_cyc[i] = cyc;
          end
      end
      step(); hs = 1'b0; en = 1'b0; data = 8'h00;
      step();
    end
    step(); vs = 1'b0;
    repeat (6) step();
  endtask

  task automatic clear_mon();
    q_main.delete(); q_ovf.delete(); q_cap.delete(); pop_cyc.delete();
    done_main = 0; done_ovf = 0; done_cap = 0;
  endtask

  typedef struct {
    int         frame;
    int         x;
    int         y;
    logic [1:0] t;
    bit         emit;
  } vec_t;

  initial begin
    vec_t tbl[7];
    int ex[$], ey[$], et[$];
    int xs[6], ys[6], ts[6];

    tbl = '{'{0, 10,  5, 2'd1, 1'b1},
            '{1,  4,  4, 2'd3, 1'b1},
            '{1, 10,  3, 2'd1, 1'b0},
            '{1,  3, 10, 2'd2, 1'b0},
            '{1, 60, 10, 2'd3, 1'b0},
            '{1, 10, 44, 2'd2, 1'b0},
            '{1, 59, 43, 2'd2, 1'b1}};

    rst = 1'b1; vs = 1'b0; hs = 1'b0; en = 1'b0; data = 8'h00;
    rdy_main = 1'b1; rdy_ovf = 1'b1; rdy_cap = 1'b1;
    repeat (3) step();
    check_main_zero("reset");
    rst = 1'b0;
    step();

    // T1/T2: table-driven frames, all consumers ready.
    for (int f = 0; f < 2; f++) begin
      fx.delete(); fy.delete(); ft.delete(); ex.delete(); ey.delete(); et.delete();
      foreach (tbl[i]) if (tbl[i].frame == f) begin
        fx.push_back(tbl[i].x); fy.push_back(tbl[i].y); ft.push_back(tbl[i].t);
        if (tbl[i].emit) begin
          ex.push_back(tbl[i].x); ey.push_back(tbl[i].y); et.push_back(int'(tbl[i].t));
        end
      end
      clear_mon();
      first_valid_cyc = -1;
      run_frame();
      check($sformatf("f%0d_rec_count", f), q_main.size(), ex.size());
      for (int i = 0; i < ex.size(); i++) begin
        if (i < q_main.size()) begin
          check($sformatf("f%0d_rec%0d_x", f, i), int'(q_main[i][23:13]), ex[i]);
          check($sformatf("f%0d_rec%0d_y", f, i), int'(q_main[i][12:2]), ey[i]);
          check($sformatf("f%0d_rec%0d_type", f, i), int'(q_main[i][1:0]), et[i]);
        end
      end
      check($sformatf("f%0d_frame_done", f), done_main, 1);
      check($sformatf("f%0d_kp_count", f), cnt_main, ex.size());
      if (f == 0) check("t1_latency", first_valid_cyc - mk_cyc[0], 3);
    end

    // T3 backpressure on main, T5 cap on the MAX_KP=3 instance.
    xs = '{5, 20, 7, 30, 40, 0}; ys = '{5, 5, 6, 20, 40, 0}; ts = '{1, 2, 3, 1, 2, 0};
    set_markers(5, xs, ys, ts);
    clear_mon();
    stab_err = 0;
    rdy_main = 1'b0;
    run_frame();
    check("t3_valid_held", int'(if_main.kp_valid), 1);
    check("t3_head_x", int'(if_main.kp_x), 5);
    check("t3_head_y", int'(if_main.kp_y), 5);
    check("t3_head_type", int'(if_main.kp_type), 1);
    check("t3_stability_errors", stab_err, 0);
    check("t3_kp_count", cnt_main, 5);
    rdy_main = 1'b1;
    repeat (8) step();
    check("t3_drained", q_main.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < q_main.size()) begin
        check($sformatf("t3_rec%0d_x", i), int'(q_main[i][23:13]), xs[i]);
        check($sformatf("t3_rec%0d_y", i), int'(q_main[i][12:2]), ys[i]);
      end
    if (pop_cyc.size() == 5) check("t3_pop_span", pop_cyc[4] - pop_cyc[0], 4);
    else check("t3_pop_cycles", pop_cyc.size(), 5);
    check("t5_records", q_cap.size(), 3);
    check("t5_kp_count", cnt_cap, 3);
    check("t5_overflow", int'(if_cap.overflow), 0);
    if (q_cap.size() == 3) check("t5_last_x", int'(q_cap[2][23:13]), 7);

    // T4 overflow on the FIFO_DEPTH=4 instance.
    xs = '{5, 6, 7, 8, 9, 10}; ys = '{5, 5, 5, 5, 5, 5}; ts = '{1, 2, 3, 1, 2, 3};
    set_markers(6, xs, ys, ts);
    clear_mon();
    rdy_ovf = 1'b0;
    run_frame();
    check("t4_overflow_set", int'(if_ovf.overflow), 1);
    check("t4_kp_count", cnt_ovf, 6);
    check("t4_main_overflow", int'(if_main.overflow), 0);
    rdy_ovf = 1'b1;
    repeat (8) step();
    check("t4_retained", q_ovf.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < q_ovf.size()) check($sformatf("t4_rec%0d_x", i), int'(q_ovf[i][23:13]), xs[i]);
    check("t4_overflow_hold", int'(if_ovf.overflow), 1);
    step(); vs = 1'b1;
    step(); step();
    check("t4_overflow_cleared", int'(if_ovf.overflow), 0);
    step(); vs = 1'b0;
    repeat (4) step();

    // T6: reset mid-frame, released while VS is high.
    xs = '{10, 30, 0, 0, 0, 0}; ys = '{20, 30, 0, 0, 0, 0}; ts = '{1, 2, 0, 0, 0, 0};
    set_markers(2, xs, ys, ts);
    clear_mon();
    rst_line = 10;
    run_frame();
    rst_line = -1;
    check("t6_no_records", q_main.size(), 0);
    check("t6_no_done", done_main, 0);
    check("t6_count_zero", int'(if_main.kp_count), 0);
    xs = '{10, 0, 0, 0, 0, 0}; ys = '{5, 0, 0, 0, 0, 0}; ts = '{3, 0, 0, 0, 0, 0};
    set_markers(1, xs, ys, ts);
    clear_mon();
    run_frame();
    check("t6_next_records", q_main.size(), 1);
    if (q_main.size() == 1) check("t6_next_rec", int'(q_main[0]), int'({11'd10, 11'd5, 2'd3}));
    check("t6_next_count", cnt_main, 1);
    check("t6_next_done", done_main, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
